// File: rtl/axi4_lite_master_if_pkg.sv
// axi4_lite_Defs: bus widths, FSM state type and response codes
// shared by the AXI4-Lite master and its watchdog.
package axi4_lite_Defs;

   localparam int Addr_Width = 32;
   localparam int Data_Width = 32;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_DATA,
      DONE
   } state_t;

endpackage

// File: rtl/axi4_lite_master_if_timeout_cnt.sv
// axi4_lite_timeout_cnt: per-state watchdog for the AXI4-Lite master,
// used only when AXI4_LITE_MASTER_TIMEOUT_EN is defined.
module axi4_lite_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic active,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q;

   // saturates so a stalled master cannot wrap back to "not expired"
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (clear)
         cnt_q <= '0;
      else if (active && !expired)
         cnt_q <= cnt_q + 1'b1;
   end

   assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi4_lite_master_if.sv
// axi4_lite_master_if: single-outstanding AXI4-Lite master.
// Optional watchdog enabled by defining AXI4_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_master_if #(
   parameter int Addr_Width     = axi4_lite_Defs::Addr_Width,
   parameter int Data_Width     = axi4_lite_Defs::Data_Width,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [Addr_Width-1:0]   cmd_addr,
   input  logic [Data_Width-1:0]   cmd_wdata,
   input  logic [Data_Width/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   output logic [Data_Width-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
   output logic                    timeout_flag,
`endif
   output logic [Addr_Width-1:0]   AWADDR,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [Data_Width-1:0]   WDATA,
   output logic [Data_Width/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic [Addr_Width-1:0]   ARADDR,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   input  logic [Data_Width-1:0]   RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    RVALID,
   output logic                    RREADY
);

   import axi4_lite_Defs::*;

   state_t state_q, state_d;

   logic aw_done_q, aw_done_d;
   logic w_done_q, w_done_d;

   logic [Addr_Width-1:0]   addr_q;
   logic [Data_Width-1:0]   wdata_q;
   logic [Data_Width/8-1:0] wstrb_q;
   logic [Data_Width-1:0]   rdata_q, rdata_d;
   logic [1:0]              resp_q, resp_d;

   logic accept;

   assign accept = cmd_valid && (state_q == IDLE);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
   logic expired;
   logic to_q, to_d;

   axi4_lite_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (ACLK),
      .rst    (ARESET),
      .clear  (state_d != state_q),
      .active (state_q != IDLE),
      .expired(expired)
   );

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)
         to_q <= 1'b0;
      else
         to_q <= to_d;
   end

   assign timeout_flag = (state_q == DONE) && to_q;
`endif

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= OKAY;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      to_d      = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = cmd_write ? WR_REQ : RD_REQ;
            end
         end
         // AW and W complete independently, in either order or together
         WR_REQ: begin
            if (AWREADY)
               aw_done_d = 1'b1;
            if (WREADY)
               w_done_d = 1'b1;
            if (aw_done_d && w_done_d)
               state_d = WR_RESP;
         end
         WR_RESP: begin
            if (BVALID) begin
               rdata_d = '0;
               resp_d  = BRESP;
               state_d = DONE;
            end
         end
         RD_REQ: begin
            if (ARREADY)
               state_d = RD_DATA;
         end
         RD_DATA: begin
            if (RVALID) begin
               rdata_d = RDATA;
               resp_d  = RRESP;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      // a normal completion on the same edge wins over the watchdog
      if (expired && (state_d == state_q) &&
          (state_q != IDLE) && (state_q != DONE)) begin
         state_d = DONE;
         rdata_d = '0;
         resp_d  = SLVERR;
         to_d    = 1'b1;
      end
`endif
   end

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == DONE);
   assign rsp_rdata = rdata_q;
   assign rsp_resp  = resp_q;

   // VALIDs decode from the async-reset state, so reset drops them at once
   assign AWVALID = (state_q == WR_REQ) && !aw_done_q;
   assign WVALID  = (state_q == WR_REQ) && !w_done_q;
   assign BREADY  = (state_q == WR_RESP);
   assign ARVALID = (state_q == RD_REQ);
   assign RREADY  = (state_q == RD_DATA);

   assign AWADDR = addr_q;
   assign ARADDR = addr_q;
   assign WDATA  = wdata_q;
   assign WSTRB  = wstrb_q;

endmodule

// File: tb/tb_axi4_lite_master_if.sv
// tb_axi4_lite_master_if: directed vector bench for the AXI4-Lite
// master, acting as host and as a configurable slave.
module tb_axi4_lite_master_if;

   logic        ACLK;
   logic        ARESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
   logic        timeout_flag;
`endif
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   int checks = 0;
   int failures = 0;

   axi4_lite_master_if #(
      .TIMEOUT_CYCLES(8)
   ) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_resp (rsp_resp),
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      .timeout_flag(timeout_flag),
`endif
      .AWADDR   (AWADDR),
      .AWVALID  (AWVALID),
      .AWREADY  (AWREADY),
      .WDATA    (WDATA),
      .WSTRB    (WSTRB),
      .WVALID   (WVALID),
      .WREADY   (WREADY),
      .BRESP    (BRESP),
      .BVALID   (BVALID),
      .BREADY   (BREADY),
      .ARADDR   (ARADDR),
      .ARVALID  (ARVALID),
      .ARREADY  (ARREADY),
      .RDATA    (RDATA),
      .RRESP    (RRESP),
      .RVALID   (RVALID),
      .RREADY   (RREADY)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          aw_wait;
      int          w_wait;
      int          ar_wait;
      int          rsp_wait;
      logic        early;
      logic        hold;
      logic [1:0]  s_resp;
      logic [31:0] s_rdata;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          exp_lat;
      int          exp_aw;
      int          exp_w;
      int          exp_ar;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic slave_idle();
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      BVALID  = 1'b0;
      BRESP   = 2'b00;
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      RDATA   = '0;
      RRESP   = 2'b00;
   endtask

   // called at a negedge; returns at a negedge
   task automatic run_vec(input int idx, input vec_t v);
      int  cyc = 0, lat = 0;
      int  aw_hi = 0, w_hi = 0, ar_hi = 0;
      int  aw_hs = 0, w_hs = 0, ar_hs = 0, rsp_hs = 0;
      int  b_ctr = 0, r_ctr = 0;
      bit  got = 0, perr = 0, b_act, r_act;
      logic [31:0] rd = '0;
      logic [1:0]  rs = '0;
      cmd_valid = 1'b1;
      cmd_write = v.wr;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_wstrb = v.strb;
      chk($sformatf("v%0d.cmd_ready_idle", idx), cmd_ready, 1);
      @(posedge ACLK);
      @(negedge ACLK);
      if (!v.hold)
         cmd_valid = 1'b0;
      while (!got && cyc < 60) begin
         cyc++;
         if (rsp_valid) begin
            got = 1;
            lat = cyc + 1;
            rd  = rsp_rdata;
            rs  = rsp_resp;
         end else begin
            if (cmd_ready) perr = 1;
            if (BREADY && (AWVALID || WVALID)) perr = 1;
            if (AWVALID && AWADDR !== v.addr) perr = 1;
            if (WVALID && (WDATA !== v.wdata || WSTRB !== v.strb))
               perr = 1;
            if (ARVALID && ARADDR !== v.addr) perr = 1;
            b_act = (aw_hs > 0) && (w_hs > 0);
            r_act = (ar_hs > 0);
            AWREADY = 1'b0;
            if (AWVALID) begin
               AWREADY = (aw_hi == v.aw_wait);
               aw_hi++;
               if (AWREADY) aw_hs++;
            end
            WREADY = 1'b0;
            if (WVALID) begin
               WREADY = (w_hi == v.w_wait);
               w_hi++;
               if (WREADY) w_hs++;
            end
            ARREADY = 1'b0;
            if (ARVALID) begin
               ARREADY = (ar_hi == v.ar_wait);
               ar_hi++;
               if (ARREADY) ar_hs++;
            end
            BRESP  = v.s_resp;
            BVALID = (rsp_hs == 0) && v.wr &&
                     (v.early || (b_act && b_ctr >= v.rsp_wait));
            if (b_act) b_ctr++;
            RDATA  = v.s_rdata;
            RRESP  = v.s_resp;
            RVALID = (rsp_hs == 0) && !v.wr && r_act &&
                     (r_ctr >= v.rsp_wait);
            if (r_act) r_ctr++;
            if ((BVALID && BREADY) || (RVALID && RREADY)) rsp_hs++;
            @(posedge ACLK);
            @(negedge ACLK);
         end
      end
      slave_idle();
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL v%0d.rsp_timeout: no rsp_valid within %0d cycles",
                  idx, cyc);
      end else begin
         chk($sformatf("v%0d.latency", idx), lat, v.exp_lat);
         chk($sformatf("v%0d.rsp_rdata", idx), rd, v.exp_rdata);
         chk($sformatf("v%0d.rsp_resp", idx), rs, v.exp_resp);
         chk($sformatf("v%0d.aw_cycles", idx), aw_hi, v.exp_aw);
         chk($sformatf("v%0d.w_cycles", idx), w_hi, v.exp_w);
         chk($sformatf("v%0d.ar_cycles", idx), ar_hi, v.exp_ar);
         chk($sformatf("v%0d.resp_handshakes", idx), rsp_hs, 1);
         chk($sformatf("v%0d.protocol", idx), perr, 0);
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
         chk($sformatf("v%0d.timeout_flag", idx), timeout_flag, 0);
`endif
         @(posedge ACLK);
         @(negedge ACLK);
         chk($sformatf("v%0d.rsp_pulse_width", idx), rsp_valid, 0);
         chk($sformatf("v%0d.cmd_ready_back", idx), cmd_ready, 1);
         chk($sformatf("v%0d.rdata_hold", idx), rsp_rdata, v.exp_rdata);
      end
   endtask

   initial begin
      int n;
      int rsp_seen;
      int ar_seen;

      vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0,
                  1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 4, 1, 1, 0};
      vecs[1] = '{1'b1, 32'h0000_0014, 32'hA5A5_0001, 4'hF, 2, 0, 0, 0,
                  1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 6, 3, 1, 0};
      vecs[2] = '{1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 0, 0, 2,
                  1'b0, 1'b0, 2'b00, 32'h1234_5678, 32'h1234_5678,
                  2'b00, 6, 0, 0, 1};
      vecs[3] = '{1'b0, 32'h0000_0024, 32'h0, 4'h0, 0, 0, 0, 0,
                  1'b0, 1'b1, 2'b10, 32'hCAFE_F00D, 32'hCAFE_F00D,
                  2'b10, 4, 0, 0, 1};
      vecs[4] = '{1'b1, 32'h0000_0030, 32'h0000_BEEF, 4'h3, 0, 1, 0, 0,
                  1'b0, 1'b0, 2'b11, 32'h0, 32'h0, 2'b11, 5, 1, 2, 0};
      vecs[5] = '{1'b1, 32'h0000_0040, 32'h1111_2222, 4'hC, 1, 1, 0, 0,
                  1'b1, 1'b0, 2'b01, 32'h0, 32'h0, 2'b01, 5, 2, 2, 0};
      vecs[6] = '{1'b0, 32'h0000_0050, 32'h0, 4'h0, 0, 0, 1, 0,
                  1'b0, 1'b0, 2'b00, 32'h0BAD_CAFE, 32'h0BAD_CAFE,
                  2'b00, 5, 0, 0, 2};

      ARESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_wstrb = '0;
      slave_idle();
      @(negedge ACLK);
      @(negedge ACLK);
      chk("rst.cmd_ready", cmd_ready, 1);
      chk("rst.valids", {AWVALID, WVALID, ARVALID}, 0);
      chk("rst.readies", {BREADY, RREADY}, 0);
      chk("rst.rsp_valid", rsp_valid, 0);
      chk("rst.rsp_rdata", rsp_rdata, 0);
      chk("rst.rsp_resp", rsp_resp, 0);
      chk("rst.addr", {AWADDR, ARADDR}, 0);
      chk("rst.wdata", {WDATA, WSTRB}, 0);
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      chk("rst.timeout_flag", timeout_flag, 0);
`endif
      ARESET = 1'b0;
      @(negedge ACLK);

      for (int i = 0; i < 6; i++)
         run_vec(i, vecs[i]);
      cmd_valid = 1'b0;

      // reset while a read address is outstanding
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0000_0060;
      @(posedge ACLK);
      @(negedge ACLK);
      cmd_valid = 1'b0;
      chk("arst.arvalid_before", ARVALID, 1);
      #2 ARESET = 1'b1;
      #1;
      chk("arst.arvalid_async_drop", ARVALID, 0);
      chk("arst.cmd_ready", cmd_ready, 1);
      @(negedge ACLK);
      ARESET = 1'b0;
      rsp_seen = 0;
      ar_seen  = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge ACLK);
         @(negedge ACLK);
         if (rsp_valid) rsp_seen++;
         if (ARVALID) ar_seen++;
      end
      chk("arst.no_rsp", rsp_seen, 0);
      chk("arst.no_reissue", ar_seen, 0);
      run_vec(6, vecs[6]);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      // write whose B response never arrives
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0070;
      cmd_wdata = 32'h5555_AAAA;
      cmd_wstrb = 4'hF;
      @(posedge ACLK);
      @(negedge ACLK);
      cmd_valid = 1'b0;
      AWREADY = 1'b1;
      WREADY  = 1'b1;
      @(posedge ACLK);
      @(negedge ACLK);
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      chk("to.bready_entry", BREADY, 1);
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge ACLK);
         @(negedge ACLK);
         n++;
      end
      chk("to.latency", n, 8);
      chk("to.rsp_valid", rsp_valid, 1);
      chk("to.rsp_resp", rsp_resp, 2'b10);
      chk("to.rsp_rdata", rsp_rdata, 0);
      chk("to.timeout_flag", timeout_flag, 1);
      chk("to.bready_dropped", BREADY, 0);
      @(posedge ACLK);
      @(negedge ACLK);
      chk("to.flag_pulse", timeout_flag, 0);
      chk("to.rsp_pulse", rsp_valid, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axi4_lite_master_if.md
Name: axi4_lite_master_if

Overview:
- Single-outstanding AXI4-Lite bus master. Converts a simple command/response handshake from the testbench or host logic into AXI4-Lite AW/W/B and AR/R channel traffic.
- Sits directly upstream of the AXI4-Lite slave and uses the bus widths from the axi4_lite_Defs package.

Parameters:
Addr_Width, 32 (package value), address width of all address ports
Data_Width, 32 (package value), data width; strobe width = Data_Width/8
TIMEOUT_CYCLES, 256, watchdog limit, used only when the optional feature is compiled in

Ports:
ACLK  in  1  bus clock; all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  Addr_Width  transaction address
cmd_wdata  in  Data_Width  write data
cmd_wstrb  in  Data_Width/8  write byte strobes
rsp_valid  out  1  one-cycle pulse when the transaction completes
rsp_rdata  out  Data_Width  read data (0 for writes)
rsp_resp  out  2  BRESP or RRESP; 2'b10 on timeout
AWADDR/AWVALID/AWREADY  out/out/in  Addr_Width/1/1  write address channel
WDATA/WSTRB/WVALID/WREADY  out/out/out/in  Data_Width/Data_Width/8/1/1  write data channel
BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
ARADDR/ARVALID/ARREADY  out/out/in  Addr_Width/1/1  read address channel
RDATA/RRESP/RVALID/RREADY  in/in/in/out  Data_Width/2/1/1  read data channel

Behaviour:
- Reset (async assert, sync release): state IDLE; every output 0 except cmd_ready = 1.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE:
  - On cmd_valid && cmd_ready, register addr, wdata and wstrb.
  - Write goes to WR_REQ; read goes to RD_REQ.
  - Next cycle, AWVALID and WVALID (write) or ARVALID (read) assert from registers.
- WR_REQ:
  - AWVALID and WVALID are tracked independently. Each drops the cycle after its own VALID&&READY.
  - Enter WR_RESP once both are done. A same-cycle handshake on AW and W counts as both done.
  - AWADDR, WDATA and WSTRB stay stable while the matching VALID is high.
  - VALID never waits on READY.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP and go to DONE.
- RD_REQ: ARVALID held until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA/RRESP and go to DONE.
- DONE: rsp_valid = 1 for exactly one cycle, then IDLE.
- Latency: cmd accept to rsp_valid is 4 cycles minimum when the slave is zero-wait (READY high, response the cycle after the address handshake).
- No overlap: cmd_valid outside IDLE is ignored; the command must be held until cmd_ready.
- rsp_rdata and rsp_resp hold their last values until the next DONE.
- An early BVALID/RVALID (before its state is reached) is not accepted until that state.
- ARESET mid-transaction:
  - All VALIDs drop immediately (asynchronous).
  - The transaction is abandoned with no rsp_valid.
- AWPROT/ARPROT are not generated.

Optional Feature:
- Macro AXI4_LITE_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to each non-IDLE state and increments every cycle there.
  - On reaching TIMEOUT_CYCLES: drop all VALID/READY, set rsp_resp = 2'b10, rsp_rdata = 0, go to DONE.
  - Output timeout_flag is added; it pulses with that rsp_valid.
- Undefined: no counter and no timeout_flag port; the block waits forever.

Decomposition:
- Shared package (axi4_lite_Defs): Addr_Width, Data_Width, the state enum typedef, and response constants OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11.
- One natural sub-module: axi4_lite_timeout_cnt (watchdog counter), instantiated only under the macro.

Test Plan:
- Zero-wait write, addr 0x0000_0010, data 0xDEAD_BEEF, strb 0xF -> AW/W valid the cycle after accept, one handshake each; BRESP 00; rsp_valid 4 cycles after accept, rsp_resp 00, rsp_rdata 0.
- Skewed write: AWREADY held 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 3 cycles with stable AWADDR; exactly one rsp_valid.
- Read of 0x0000_0020, slave returns RDATA 0x1234_5678, RRESP 00 after 2 wait cycles -> rsp_rdata 0x1234_5678, rsp_valid pulse width 1.
- Read with RRESP 10 -> rsp_resp 10; cmd_valid held during the transaction is not accepted until cmd_ready returns.
- ARESET asserted while ARVALID = 1 -> ARVALID = 0 in the same cycle; no rsp_valid; next command completes normally.
- With AXI4_LITE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, BVALID never asserted -> rsp_valid 8 cycles after WR_RESP entry, rsp_resp 10, timeout_flag = 1.
